// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - two-digit seven-segment scanner with blanking and double-buffered updates
// Optional blink feature: define SEVSEG_BLINK_EN to add the blink input and BLINK_FRAMES parameter.
module seven_seg_scanner #(
  parameter int DWELL = 16,
  parameter int BLANK = 2
`ifdef SEVSEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef SEVSEG_BLINK_EN
  input  logic       blink,
`endif
  input  logic       load,
  input  logic [7:0] seg_in1,
  input  logic [7:0] seg_in2,
  output logic       ready,
  output logic [7:0] seg_out,
  output logic [1:0] dig_en,
  output logic       frame_done
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] SLOT_BLANK = CW'(BLANK);

  // Scan position: cycle within the slot and which digit owns the slot
  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic          idx_q, idx_d;

  // Patterns on the glass and the pending buffer awaiting the next frame boundary
  logic [7:0]    disp1_q, disp1_d;
  logic [7:0]    disp2_q, disp2_d;
  logic [7:0]    pend1_q, pend1_d;
  logic [7:0]    pend2_q, pend2_d;
  logic          pend_v_q, pend_v_d;

  logic          slot_end;
  logic          frame_end;
  logic          blanked;

`ifdef SEVSEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          phase_q, phase_d;
`endif

  assign slot_end  = (slot_cnt_q == SLOT_LAST);
  assign frame_end = idx_q && slot_end;

  // Free-running slot counter; the digit index flips each time a slot completes
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    idx_d      = idx_q;
    if (slot_end) begin
      slot_cnt_d = '0;
      idx_d      = ~idx_q;
    end else begin
      slot_cnt_d = slot_cnt_q + 1'b1;
    end
  end

  // Double buffer: loads park in the pending buffer, and the display only changes at a frame end
  always_comb begin
    disp1_d  = disp1_q;
    disp2_d  = disp2_q;
    pend1_d  = pend1_q;
    pend2_d  = pend2_q;
    pend_v_d = pend_v_q;
    if (frame_end) begin
      // A load landing on the frame-end edge is newer than anything pending, so it wins
      if (load) begin
        disp1_d = seg_in1;
        disp2_d = seg_in2;
      end else if (pend_v_q) begin
        disp1_d = pend1_q;
        disp2_d = pend2_q;
      end
      pend_v_d = 1'b0;
    end else if (load) begin
      pend1_d  = seg_in1;
      pend2_d  = seg_in2;
      pend_v_d = 1'b1;
    end
  end

`ifdef SEVSEG_BLINK_EN
  // Blink phase advances every BLINK_FRAMES completed frames
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (frame_end) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end
`endif

  // State registers; reset discards all buffered data and restarts the scan blanked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q <= '0;
      idx_q      <= 1'b0;
      disp1_q    <= 8'h00;
      disp2_q    <= 8'h00;
      pend1_q    <= 8'h00;
      pend2_q    <= 8'h00;
      pend_v_q   <= 1'b0;
`ifdef SEVSEG_BLINK_EN
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
`endif
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      disp1_q    <= disp1_d;
      disp2_q    <= disp2_d;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      pend_v_q   <= pend_v_d;
`ifdef SEVSEG_BLINK_EN
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
`endif
    end
  end

`ifdef SEVSEG_BLINK_EN
  assign blanked = (slot_cnt_q < SLOT_BLANK) || (blink && phase_q);
`else
  assign blanked = (slot_cnt_q < SLOT_BLANK);
`endif

  // Output decode from registered state only; blanking gap at the head of every slot
  always_comb begin
    seg_out    = 8'h00;
    dig_en     = 2'b00;
    frame_done = frame_end;
    ready      = ~pend_v_q;
    if (!blanked) begin
      if (idx_q) begin
        seg_out = disp2_q;
        dig_en  = 2'b10;
      end else begin
        seg_out = disp1_q;
        dig_en  = 2'b01;
      end
    end
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Downstream display stage of the hex-to-seven-segment decoder.
- Takes the decoder's two 8-bit segment patterns and time-multiplexes them onto one shared segment bus with per-digit enables.
- Inserts a blanking interval at every digit switch to suppress ghosting.
- Double-buffers updates so a frame never shows half-old, half-new data.

Parameters:
DWELL, 16, clock cycles per digit slot; must be > BLANK; frame = 2*DWELL cycles
BLANK, 2, cycles at the start of each slot with segments and enables forced off

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Load  input  1  capture SegIn1/SegIn2 this cycle
SegIn1  input  8  digit-1 pattern, bit7=dp, bit6=g … bit0=a, active-high
SegIn2  input  8  digit-2 pattern, same encoding
Ready  output  1  high when no update is pending
SegOut  output  8  shared segment bus, active-high
DigEn  output  2  one-hot digit enable, active-high; bit0=digit 1, bit1=digit 2
FrameDone  output  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- State registers:
  - SlotCnt, 0..DWELL-1
  - Idx, 0/1: current digit slot
  - Disp1, Disp2: displayed patterns
  - Pend1, Pend2, PendV: pending buffer
- Cycle k: state after k rising edges following Rst_n deassertion.
- Reset (async, Rst_n=0), applied immediately without a clock:
  - SlotCnt=0, Idx=0, Disp*=0, Pend*=0, PendV=0
  - Outputs: SegOut=00, DigEn=00, Ready=1, FrameDone=0
- Counter, every edge:
  - SlotCnt increments.
  - At DWELL-1, SlotCnt wraps to 0 and Idx toggles.
- Outputs decode from the current registers only; there is no input-to-output path.
  - SlotCnt<BLANK: SegOut=00, DigEn=00.
  - Otherwise: SegOut=Disp1 with DigEn=01 when Idx=0; SegOut=Disp2 with DigEn=10 when Idx=1.
  - FrameDone=1 iff Idx=1 and SlotCnt=DWELL-1.
  - Ready = !PendV.
- Load handling (the frame-end edge is the edge leaving Idx=1, SlotCnt=DWELL-1):
  - Load on a non-frame-end edge: Pend<=SegIn, PendV<=1. A later Load before frame end overwrites the pending values (last wins).
  - Frame-end edge, PendV=1, Load=0: Disp<=Pend, PendV<=0.
  - Frame-end edge with Load=1: Disp<=SegIn directly and PendV<=0, regardless of any older pending data.
  - Disp changes only at frame-end edges, so a frame always shows a consistent pair.
- Ready gives status only; Load is never refused.
- Reset mid-frame: all buffered data is discarded and scanning restarts at cycle 0, blanked.

Optional Feature:
- Macro SEVSEG_BLINK_EN.
- Defined:
  - Adds input Blink (1 bit) and parameter BLINK_FRAMES (default 4).
  - A frame counter wraps every BLINK_FRAMES frames; a phase bit toggles on each wrap. Both reset to 0.
  - When Blink=1 and phase=1: SegOut=00 and DigEn=00 for the whole frame.
  - Scanning, FrameDone, Ready and Load are unaffected.
- Undefined: no Blink port, no frame counter, never blanked beyond BLANK.

Test Plan:
- Reset (defaults):
  - During Rst_n=0: SegOut=00, DigEn=00, Ready=1, FrameDone=0.
  - Cycles 0-1: DigEn=00.
  - Cycles 2-15: DigEn=01, SegOut=00.
  - Cycles 16-17: DigEn=00.
  - Cycles 18-31: DigEn=10.
  - FrameDone=1 only at cycle 31.
- Load SegIn1=0x5E, SegIn2=0x5B at cycle 5:
  - Ready=0 at cycles 6-31, back to 1 at cycle 32.
  - Cycles 34-47: SegOut=0x5E, DigEn=01.
  - Cycles 50-63: SegOut=0x5B, DigEn=10.
  - Cycles 32-33 and 48-49: SegOut=00.
- Load 0x06/0x3F at cycle 40, then 0x4F/0x66 at cycle 50:
  - Frame starting at cycle 64 shows 0x4F then 0x66.
  - 0x06 never appears.
- Load 0x7D/0x07 exactly at cycle 31:
  - Ready stays 1.
  - Cycles 34-47: SegOut=0x7D; cycles 50-63: SegOut=0x07.
- Reset mid-frame:
  - After the case above, drop Rst_n at cycle 40 (between edges).
  - SegOut=00 and DigEn=00 immediately.
  - After release, the first frame shows SegOut=00 in both slots.
- SEVSEG_BLINK_EN, Blink=1, display 0x5E/0x5B:
  - Frames 0-3 displayed normally.
  - Frames 4-7 fully dark.
  - Frames 8-11 displayed.
  - FrameDone pulses every 32 cycles throughout.
